// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the memory/IO responder: IO window layout,
// bus direction encodings and the byte type.
package mem_io_responder_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [31:0] IO_BASE       = 32'h0003_0000;
    localparam logic [31:0] UART_PORT_OFS = 32'd0;
    localparam logic [31:0] END_PORT_OFS  = 32'd4;

    localparam logic MEM_R = 1'b0;
    localparam logic MEM_W = 1'b1;

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Show-ahead synchronous FIFO: head is visible whenever the FIFO is non-empty.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte RAM plus IO window (UART TX FIFO, end-of-simulation port) behind the
// CPU memory bus. Define MEM_IO_RX_EN to add the UART receive path.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH = 17,
    parameter logic [31:0] IO_BASE        = mem_io_responder_pkg::IO_BASE,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_overflow,
    output logic        sim_end,
    output logic [7:0]  sim_end_code
`ifdef MEM_IO_RX_EN
    ,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    byte_t                     ram [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      is_ram;
    logic                      is_uart;
    logic                      is_end;
    logic                      bus_rd;
    logic                      bus_wr;
    byte_t                     rd_data;

    logic                      uart_push;
    logic                      push_accept;
    logic                      pop_fire;
    byte_t                     fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             count_next;

    assign ram_idx = mem_a[RAM_ADDR_WIDTH-1:0];
    assign is_ram  = (mem_a < IO_BASE);
    assign is_uart = (mem_a == IO_BASE + UART_PORT_OFS);
    assign is_end  = (mem_a == IO_BASE + END_PORT_OFS);
    assign bus_rd  = rdy_in && (mem_wr == MEM_R);
    assign bus_wr  = rdy_in && (mem_wr == MEM_W);

    // TX handshake: a byte moves to the consumer on every cycle where
    // tx_valid && tx_ready; tx_data is stable while tx_valid is high and
    // not accepted. Draining is independent of rdy_in.
    assign uart_push   = bus_wr && is_uart;
    assign pop_fire    = tx_ready && !fifo_empty;
    assign push_accept = uart_push && (!fifo_full || pop_fire);
    assign tx_valid    = !fifo_empty;
    assign tx_data     = fifo_empty ? 8'h00 : fifo_head;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push_accept),
        .push_data (mem_dout),
        .pop       (pop_fire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        count_next = fifo_count;
        if (push_accept && !pop_fire)      count_next = fifo_count + CW'(1);
        else if (!push_accept && pop_fire) count_next = fifo_count - CW'(1);
    end

    always_comb begin
        rd_data = 8'h00;
        if (is_ram) rd_data = ram[ram_idx];
`ifdef MEM_IO_RX_EN
        else if (is_uart && rx_valid) rd_data = rx_data;
`endif
    end

`ifdef MEM_IO_RX_EN
    assign rx_ready = bus_rd && is_uart && rx_valid;
`endif

    always_ff @(posedge clk_in) begin
        if (bus_wr && is_ram) ram[ram_idx] <= mem_dout;
    end

    // Writes and idle (rdy_in low) cycles leave the last read value in place.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (bus_rd) begin
            mem_din <= rd_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            sim_end        <= 1'b0;
            sim_end_code   <= 8'h00;
        end else begin
            io_buffer_full <= (FIFO_DEPTH - int'(count_next)) <= FULL_MARGIN;
            if (uart_push && !push_accept) tx_overflow <= 1'b1;
            if (bus_wr && is_end) begin
                sim_end      <= 1'b1;
                sim_end_code <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (default build; the
// receive-path scenario is compiled in when MEM_IO_RX_EN is defined).
module tb_mem_io_responder;

    localparam logic [31:0] IOB = 32'h0003_0000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_overflow;
    logic        sim_end;
    logic [7:0]  sim_end_code;
`ifdef MEM_IO_RX_EN
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_overflow    (tx_overflow),
        .sim_end        (sim_end),
        .sim_end_code   (sim_end_code)
`ifdef MEM_IO_RX_EN
        ,
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready)
`endif
    );

    // Clock / reset block
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are observed at the same point.
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        mem_a    = IOB + 32'd8;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = 1'b1;
        mem_dout = d;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        mem_a  = a;
        mem_wr = 1'b0;
        cyc();
        idle();
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        idle();
        cyc();
        rst_in = 1'b0;
    endtask

    // Scoreboard: pops the consumer side until the expected queue is empty.
    task automatic drain_and_check();
        logic [7:0] e;
        tx_ready = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin
                failures++;
                $display("FAIL drain_byte got valid=%b data=%h exp valid=1 data=%h", tx_valid, tx_data, e);
            end
            cyc();
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got tx_valid=%b exp 0", tx_valid);
        end
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        tx_ready = 1'b0;
        idle();
        cyc();
        cyc();
        rst_in = 1'b0;
        checks++;
        if ({mem_din, io_buffer_full, tx_valid, tx_data, tx_overflow, sim_end, sim_end_code} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs got din=%h full=%b v=%b d=%h ovf=%b end=%b code=%h exp all 0",
                     mem_din, io_buffer_full, tx_valid, tx_data, tx_overflow, sim_end, sim_end_code);
        end
    endtask

    task automatic test_ram();
        wr(32'h0000_0100, 8'h5A);
        checks++;
        if (mem_din !== 8'h00) begin
            failures++;
            $display("FAIL ram_din_before_read got %h exp 00", mem_din);
        end
        rd(32'h0000_0100);
        checks++;
        if (mem_din !== 8'h5A) begin
            failures++;
            $display("FAIL ram_read got %h exp 5a", mem_din);
        end
        rd(IOB + 32'd8);
        checks++;
        if (mem_din !== 8'h00) begin
            failures++;
            $display("FAIL io_other_read got %h exp 00", mem_din);
        end
        rd(32'h0002_0100);
        checks++;
        if (mem_din !== 8'h5A) begin
            failures++;
            $display("FAIL ram_alias got %h exp 5a", mem_din);
        end
        wr(32'h0001_FFFF, 8'hC3);
        rd(32'h0001_FFFF);
        checks++;
        if (mem_din !== 8'hC3) begin
            failures++;
            $display("FAIL ram_top_byte got %h exp c3", mem_din);
        end
        rd(32'h0000_0100);
        checks++;
        if (mem_din !== 8'h5A) begin
            failures++;
            $display("FAIL ram_no_clobber got %h exp 5a", mem_din);
        end
    endtask

    task automatic test_uart_basic();
        tx_ready = 1'b1;
        wr(IOB, 8'h48);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin
            failures++;
            $display("FAIL uart_first got v=%b d=%h exp v=1 d=48", tx_valid, tx_data);
        end
        wr(IOB, 8'h69);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin
            failures++;
            $display("FAIL uart_second got v=%b d=%h exp v=1 d=69", tx_valid, tx_data);
        end
        cyc();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_overflow !== 1'b0) begin
            failures++;
            $display("FAIL uart_empty got v=%b d=%h ovf=%b exp 0 00 0", tx_valid, tx_data, tx_overflow);
        end
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            wr(IOB, 8'h10 + 8'(i));
            if (i < 8) exp_q.push_back(8'h10 + 8'(i));
            if (i == 4) begin
                checks++;
                if (io_buffer_full !== 1'b0) begin
                    failures++;
                    $display("FAIL full_after5 got %b exp 0", io_buffer_full);
                end
            end
            if (i == 5) begin
                checks++;
                if (io_buffer_full !== 1'b1) begin
                    failures++;
                    $display("FAIL full_after6 got %b exp 1", io_buffer_full);
                end
            end
            if (i == 7) begin
                checks++;
                if (tx_overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_after8 got %b exp 0", tx_overflow);
                end
            end
            if (i == 8) begin
                checks++;
                if (tx_overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_after9 got %b exp 1", tx_overflow);
                end
            end
        end
        drain_and_check();
        checks++;
        if (io_buffer_full !== 1'b0 || tx_overflow !== 1'b1) begin
            failures++;
            $display("FAIL post_drain got full=%b ovf=%b exp 0 1", io_buffer_full, tx_overflow);
        end
    endtask

    task automatic test_full_pop();
        pulse_reset();
        tx_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            wr(IOB, 8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        checks++;
        if (io_buffer_full !== 1'b1 || tx_overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill8 got full=%b ovf=%b exp 1 0", io_buffer_full, tx_overflow);
        end
        tx_ready = 1'b1;
        wr(IOB, 8'hEE);
        void'(exp_q.pop_front());
        exp_q.push_back(8'hEE);
        checks++;
        if (io_buffer_full !== 1'b1 || tx_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop got full=%b ovf=%b exp 1 0", io_buffer_full, tx_overflow);
        end
        drain_and_check();
    endtask

    task automatic test_end();
        wr(IOB + 32'd4, 8'h7B);
        checks++;
        if (sim_end !== 1'b1 || sim_end_code !== 8'h7B) begin
            failures++;
            $display("FAIL end_first got end=%b code=%h exp 1 7b", sim_end, sim_end_code);
        end
        wr(IOB + 32'd4, 8'h11);
        wr(IOB + 32'd8, 8'h99);
        checks++;
        if (sim_end !== 1'b1 || sim_end_code !== 8'h11) begin
            failures++;
            $display("FAIL end_overwrite got end=%b code=%h exp 1 11", sim_end, sim_end_code);
        end
        tx_ready = 1'b0;
        wr(IOB, 8'h01);
        wr(IOB, 8'h02);
        wr(IOB, 8'h03);
        pulse_reset();
        checks++;
        if ({sim_end, sim_end_code, tx_valid, tx_data, io_buffer_full, tx_overflow} !== 20'h0) begin
            failures++;
            $display("FAIL end_reset got end=%b code=%h v=%b d=%h full=%b ovf=%b exp all 0",
                     sim_end, sim_end_code, tx_valid, tx_data, io_buffer_full, tx_overflow);
        end
        tx_ready = 1'b1;
        wr(IOB, 8'hAA);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin
            failures++;
            $display("FAIL post_reset_push got v=%b d=%h exp 1 aa", tx_valid, tx_data);
        end
        cyc();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_count got v=%b exp 0", tx_valid);
        end
    endtask

    task automatic test_rdy();
        wr(32'h0000_0200, 8'h33);
        rd(32'h0000_0200);
        rdy_in   = 1'b0;
        tx_ready = 1'b0;
        mem_a    = 32'h0000_0200;
        mem_wr   = 1'b1;
        mem_dout = 8'hCC;
        cyc();
        mem_a  = IOB + 32'd8;
        mem_wr = 1'b0;
        cyc();
        checks++;
        if (mem_din !== 8'h33) begin
            failures++;
            $display("FAIL rdy_hold_din got %h exp 33", mem_din);
        end
        mem_a    = IOB;
        mem_wr   = 1'b1;
        mem_dout = 8'h55;
        cyc();
        mem_a = IOB + 32'd4;
        cyc();
        checks++;
        if (tx_valid !== 1'b0 || sim_end !== 1'b0) begin
            failures++;
            $display("FAIL rdy_no_io got v=%b end=%b exp 0 0", tx_valid, sim_end);
        end
        idle();
        rdy_in = 1'b1;
        rd(32'h0000_0200);
        checks++;
        if (mem_din !== 8'h33) begin
            failures++;
            $display("FAIL rdy_ram_unchanged got %h exp 33", mem_din);
        end
        wr(IOB, 8'h77);
        rdy_in   = 1'b0;
        tx_ready = 1'b1;
        cyc();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rdy_drain got v=%b exp 0", tx_valid);
        end
        rdy_in = 1'b1;
    endtask

`ifdef MEM_IO_RX_EN
    task automatic test_rx();
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        mem_a    = IOB;
        mem_wr   = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rx_ready_pulse got %b exp 1", rx_ready);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (mem_din !== 8'h31 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rx_data got din=%h rdy=%b exp 31 0", mem_din, rx_ready);
        end
        rx_valid = 1'b0;
        mem_a    = IOB;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rx_no_valid_ready got %b exp 0", rx_ready);
        end
        cyc();
        idle();
        checks++;
        if (mem_din !== 8'h00) begin
            failures++;
            $display("FAIL rx_no_valid_din got %h exp 00", mem_din);
        end
    endtask
`else
    task automatic test_uart_read();
        rd(32'h0000_0100);
        rd(IOB);
        checks++;
        if (mem_din !== 8'h00) begin
            failures++;
            $display("FAIL uart_read_zero got %h exp 00", mem_din);
        end
    endtask
`endif

    initial begin
`ifdef MEM_IO_RX_EN
        rx_valid = 1'b0;
        rx_data  = 8'h00;
`endif
        test_reset();
        test_ram();
        test_uart_basic();
        test_overflow();
        test_full_pop();
        test_end();
        test_rdy();
`ifdef MEM_IO_RX_EN
        test_rx();
`else
        test_uart_read();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
